// File: rtl/pe_pkg.sv
// Shared types, defaults and the result post-processing used by the PE grid.
package pe_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int OUT_W_DEF  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FLUSH = ST_FLUSH,
    DRAIN = ST_DRAIN
  } state_t;

  // Round half up, shift, then clamp into the output range. Works in 66 bits so
  // the rounding add can never overflow for any accumulator up to 64 bits.
  function automatic logic [63:0] round_shift_sat(
    input logic [63:0] acc,
    input int          acc_w,
    input logic [4:0]  sh,
    input logic        sgn,
    input int          out_w
  );
    logic signed [65:0] x, hi, lo;
    x = signed'({2'b00, acc});
    if (sgn) x = (x <<< (66 - acc_w)) >>> (66 - acc_w);
    if (sh != 5'd0) x = x + (66'sd1 <<< (sh - 5'd1));
    x  = x >>> sh;
    hi = sgn ? (66'sd1 <<< (out_w - 1)) - 66'sd1 : (66'sd1 <<< out_w) - 66'sd1;
    lo = sgn ? -(66'sd1 <<< (out_w - 1)) : 66'sd0;
    if (x > hi)      x = hi;
    else if (x < lo) x = lo;
    return x[63:0];
  endfunction
endpackage

// File: rtl/pe_grid_drain_cell.sv
// One MAC accumulator: clear-and-load, enable, signed/unsigned operands.
module pe_mac_cell
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iClr,
  input  logic              iSigned,
  input  logic [DATA_W-1:0] iData,
  input  logic [DATA_W-1:0] iWeight,
  output logic [ACC_W-1:0]  oAcc
);
  logic [2*DATA_W-1:0] opd, opw, prod;
  logic [ACC_W-1:0]    prod_s, prod_u, prod_ext;

  // Extending operands to the product width makes the low half of the plain
  // multiply the correct two's-complement product in signed mode.
  assign opd      = iSigned ? {{DATA_W{iData[DATA_W-1]}}, iData}     : {{DATA_W{1'b0}}, iData};
  assign opw      = iSigned ? {{DATA_W{iWeight[DATA_W-1]}}, iWeight} : {{DATA_W{1'b0}}, iWeight};
  assign prod     = opd * opw;
  assign prod_s   = ACC_W'($signed(prod));
  assign prod_u   = ACC_W'(prod);
  assign prod_ext = iSigned ? prod_s : prod_u;

  // Clear keeps a simultaneous MAC; otherwise accumulate modulo 2^ACC_W.
  always_ff @(posedge iClk) begin
    if (iRst)     oAcc <= '0;
    else if (iClr) oAcc <= iEn ? prod_ext : '0;
    else if (iEn)  oAcc <= oAcc + prod_ext;
  end
endmodule

// File: rtl/pe_grid_drain.sv
// BLOCK_NUM x ARRAY_NUM MAC grid with systolic weight chain and a
// flush-then-drain sequencer emitting one rounded, saturated row per cycle.
module pe_grid_drain
  import pe_pkg::*;
#(
  parameter  int ARRAY_NUM = 3,
  parameter  int BLOCK_NUM = 3,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int ACC_W     = ACC_W_DEF,
  parameter  int OUT_W     = OUT_W_DEF,
  localparam int ROW_W     = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iValid,
  input  logic [DATA_W-1:0]                 iWeight,
  input  logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] iData,
  input  logic                              iSigned,
  input  logic                              iClearAcc,
  input  logic                              iDrainStart,
  input  logic [4:0]                        iShift,
  output logic                              oBusy,
  output logic                              oResultValid,
  output logic [ROW_W-1:0]                  oResultRow,
  output logic [OUT_W*ARRAY_NUM-1:0]        oResult,
  output logic                              oDrainDone
);
  state_t state, state_nxt;
  logic [BLOCK_NUM-1:0][ARRAY_NUM-1:0][DATA_W-1:0] d_reg;
  logic [BLOCK_NUM-1:0][DATA_W-1:0]                w;
  logic [BLOCK_NUM-1:0]                            v;
  logic [BLOCK_NUM-1:0][ARRAY_NUM-1:0][ACC_W-1:0]  acc;
  logic [ARRAY_NUM-1:0][ACC_W-1:0]                 acc_sel;
  logic [ARRAY_NUM-1:0][OUT_W-1:0]                 res;
  logic [ROW_W-1:0]                                row_cnt;
  logic [4:0]                                      shift_r;
  logic                                            mode_r, clr_ok, last_row;

  assign oBusy    = (state != IDLE);
  assign clr_ok   = iClearAcc & (state == IDLE);
  assign last_row = (row_cnt == ROW_W'(BLOCK_NUM - 1));

  // Input registers plus weight/valid chains; new work is refused while busy.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      d_reg <= '0;
      w     <= '0;
      v     <= '0;
    end else begin
      d_reg <= iData;
      w[0]  <= iWeight;
      v[0]  <= iValid & ~oBusy;
      for (int b = 1; b < BLOCK_NUM; b++) begin
        w[b] <= w[b-1];
        v[b] <= v[b-1];
      end
    end
  end

  genvar gb, ga;
  generate
    for (gb = 0; gb < BLOCK_NUM; gb++) begin : g_row
      for (ga = 0; ga < ARRAY_NUM; ga++) begin : g_lane
        pe_mac_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_cell (
          .iClk    (iClk),
          .iRst    (iRst),
          .iEn     (v[gb]),
          .iClr    (clr_ok),
          .iSigned (mode_r),
          .iData   (d_reg[gb][ga]),
          .iWeight (w[gb]),
          .oAcc    (acc[gb][ga])
        );
      end
    end
  endgenerate

  assign acc_sel = acc[row_cnt];

  generate
    for (ga = 0; ga < ARRAY_NUM; ga++) begin : g_post
      assign res[ga] = OUT_W'(round_shift_sat(64'(acc_sel[ga]), ACC_W, shift_r, mode_r, OUT_W));
    end
  endgenerate

  // State, row counter, mode and captured shift.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      row_cnt <= '0;
      shift_r <= '0;
      mode_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_cnt <= (state == DRAIN) ? row_cnt + ROW_W'(1) : '0;
      if (clr_ok) mode_r <= iSigned;
      if (state == IDLE && iDrainStart)
        shift_r <= (iShift > 5'(ACC_W - 1)) ? 5'(ACC_W - 1) : iShift;
    end
  end

  // Next state: flush until the valid chain is empty, then one row per cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iDrainStart) state_nxt = FLUSH;
      FLUSH:   if (v == '0)     state_nxt = DRAIN;
      DRAIN:   if (last_row)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered output beat; oResult holds between beats.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oResultValid <= 1'b0;
      oResultRow   <= '0;
      oResult      <= '0;
      oDrainDone   <= 1'b0;
    end else if (state == DRAIN) begin
      oResultValid <= 1'b1;
      oResultRow   <= row_cnt;
      oResult      <= res;
      oDrainDone   <= last_row;
    end else begin
      oResultValid <= 1'b0;
      oDrainDone   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pe_grid_drain.sv
// Directed bench for pe_grid_drain (3x3 grid, 8-bit operands, 24-bit acc).
module tb_pe_grid_drain;
  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iValid = 1'b0;
  logic [7:0]  iWeight = '0;
  logic [71:0] iData = '0;
  logic        iSigned = 1'b0;
  logic        iClearAcc = 1'b0;
  logic        iDrainStart = 1'b0;
  logic [4:0]  iShift = '0;
  logic        oBusy, oResultValid, oDrainDone;
  logic [1:0]  oResultRow;
  logic [23:0] oResult;

  int tests = 0;
  int fails = 0;

  pe_grid_drain dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iWeight(iWeight), .iData(iData),
    .iSigned(iSigned), .iClearAcc(iClearAcc), .iDrainStart(iDrainStart), .iShift(iShift),
    .oBusy(oBusy), .oResultValid(oResultValid), .oResultRow(oResultRow),
    .oResult(oResult), .oDrainDone(oDrainDone)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk); #1;
  endtask

  task automatic clear(input logic sgn);
    iSigned = sgn; iClearAcc = 1'b1; step(); iClearAcc = 1'b0;
  endtask

  // n valid beats of weight wt with every cell's data = d, then let the chain empty.
  task automatic feed(input logic [7:0] wt, input logic [7:0] d, input int n);
    iWeight = wt; iData = {9{d}}; iValid = 1'b1;
    repeat (n) step();
    iValid = 1'b0;
    repeat (4) step();
  endtask

  // Start a drain and check every beat; all rows are expected to carry expv.
  task automatic drain(input string tag, input logic [4:0] sh, input logic [7:0] expv,
                       input logic with_valid, input logic poke, input int first_exp);
    int beats, first;
    beats = 0; first = -1;
    iShift = sh; iDrainStart = 1'b1; iValid = with_valid;
    step();
    iDrainStart = 1'b0; iValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge iClk);
      if (oResultValid) begin
        if (first < 0) first = i;
        chk({tag, "_row"}, 64'(oResultRow), 64'(beats));
        chk({tag, "_res"}, 64'(oResult), 64'({3{expv}}));
        chk({tag, "_done"}, 64'(oDrainDone), 64'(beats == 2));
        beats++;
      end
      if (poke) begin
        iValid = (i == 1); iClearAcc = (i == 1); iDrainStart = (i == 1);
      end
    end
    chk({tag, "_beats"}, 64'(beats), 64'd3);
    chk({tag, "_lat"}, 64'(first), 64'(first_exp));
    chk({tag, "_idle"}, 64'(oBusy), 64'd0);
  endtask

  initial begin
    logic found;
    int dones;
    step(); step();
    @(negedge iClk);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_valid", 64'(oResultValid), 64'd0);
    chk("rst_result", 64'(oResult), 64'd0);
    chk("rst_done", 64'(oDrainDone), 64'd0);
    iRst = 1'b0;
    step();

    // unsigned 3*2
    clear(1'b0); feed(8'd3, 8'd2, 1);
    drain("basic", 5'd0, 8'd6, 1'b0, 1'b0, 2);

    // signed -4*5 four times = -80
    clear(1'b1); feed(8'hFC, 8'd5, 4);
    drain("sgn_sh2", 5'd2, 8'hEC, 1'b0, 1'b0, 2);
    drain("sgn_sh3", 5'd3, 8'hF6, 1'b0, 1'b0, 2);
    clear(1'b1); feed(8'd3, 8'd2, 1);
    drain("round", 5'd2, 8'd2, 1'b0, 1'b0, 2);

    // saturation and shift clamp: 65*65025 = 4226625, (x + 2^22) >> 23 = 1
    clear(1'b0); feed(8'hFF, 8'hFF, 2);
    drain("sat_u", 5'd0, 8'hFF, 1'b0, 1'b0, 2);
    feed(8'hFF, 8'hFF, 63);
    drain("sh_clamp", 5'd31, 8'd1, 1'b0, 1'b0, 2);
    clear(1'b1); feed(8'h7F, 8'h7F, 1);
    drain("sat_pos", 5'd0, 8'h7F, 1'b0, 1'b0, 2);
    clear(1'b1); feed(8'h80, 8'h7F, 1);
    drain("sat_neg", 5'd0, 8'h80, 1'b0, 1'b0, 2);

    // clear-and-load: acc 100, then clear lands on row 0's valid cycle with product 12
    clear(1'b0); feed(8'd10, 8'd10, 1);
    iWeight = 8'd3; iData = {9{8'd4}}; iValid = 1'b1; step();
    iValid = 1'b0; iClearAcc = 1'b1; step();
    iClearAcc = 1'b0; repeat (4) step();
    drain("clr_load", 5'd0, 8'd12, 1'b0, 1'b0, 2);

    // valid with drain start is accepted; flush waits for it
    clear(1'b0); iWeight = 8'd2; iData = {9{8'd3}};
    drain("ilk", 5'd0, 8'd6, 1'b1, 1'b0, 5);
    drain("poke", 5'd0, 8'd6, 1'b0, 1'b1, 2);
    drain("post_poke", 5'd0, 8'd6, 1'b0, 1'b0, 2);

    // reset after row 1 has been emitted
    iShift = 5'd0; iDrainStart = 1'b1; step(); iDrainStart = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!found) begin
        @(negedge iClk);
        if (oResultValid && oResultRow == 2'd1) found = 1'b1;
      end
    end
    chk("mid_row1_seen", 64'(found), 64'd1);
    iRst = 1'b1; step();
    @(negedge iClk);
    chk("mid_busy", 64'(oBusy), 64'd0);
    chk("mid_valid", 64'(oResultValid), 64'd0);
    iRst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iClk);
      if (oDrainDone || oResultValid) dones++;
    end
    chk("mid_no_done", 64'(dones), 64'd0);
    drain("after_rst", 5'd0, 8'd0, 1'b0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
